// File: rtl/ew_size_store_and_fetch_pkg.sv
// Shared widths, FSM encoding and helpers for the event-window size store/fetch block.
package ew_size_store_and_fetch_pkg;

    localparam int EVENT_TAG_BITS    = 48;
    localparam int EW_SIZE_BITS      = 10;
    localparam int EW_SIZE_ADDR_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CMP  = 2'd2,
        ST_WAIT = 2'd3
    } fetch_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/ew_size_store_and_fetch_if.sv
// Store and fetch handshake between the tag source, ewtag_cntrl and the size store.
interface ew_size_store_and_fetch_if
    import ew_size_store_and_fetch_pkg::*;
#(
    parameter int SIZE_BITS = EW_SIZE_BITS
);
    logic                      store_we;
    logic [EVENT_TAG_BITS-1:0] store_tag;
    logic [SIZE_BITS-1:0]      store_size;
    logic                      tag_fetch;
    logic [EVENT_TAG_BITS-1:0] evt_tag_fetch;
    logic                      tag_valid;
    logic [SIZE_BITS-1:0]      fetch_size;
    logic                      fetch_hit;
    logic                      fetch_timeout;

    modport master (
        output store_we, store_tag, store_size, tag_fetch, evt_tag_fetch,
        input  tag_valid, fetch_size, fetch_hit, fetch_timeout
    );

    modport slave (
        input  store_we, store_tag, store_size, tag_fetch, evt_tag_fetch,
        output tag_valid, fetch_size, fetch_hit, fetch_timeout
    );
endinterface

// File: rtl/ew_size_store_and_fetch_ram.sv
// Simple dual-port record RAM with a registered read; a same-address write is forwarded.
module ew_size_ram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 58
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [DATA_BITS-1:0] rdata_r;

    // Record storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, write-first on address collision
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (we && (waddr == raddr)) begin
            rdata_r <= wdata;
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/ew_size_store_and_fetch.sv
// Stores per-event-window size records keyed by EWTAG and answers fetch requests,
// waiting for tags newer than the last stored one until they arrive or time out.
module ew_size_store_and_fetch
    import ew_size_store_and_fetch_pkg::*;
#(
    parameter int          ADDR_BITS   = EW_SIZE_ADDR_BITS,
    parameter int          SIZE_BITS   = EW_SIZE_BITS,
    parameter logic [15:0] WAIT_CYCLES = 16'd4000
) (
    input  logic                          dreqclk,
    input  logic                          reset_dreqclk,
    ew_size_store_and_fetch_if.slave      bus,
    output logic [15:0]                   store_cnt,
    output logic [15:0]                   fetch_cnt,
    output logic [15:0]                   miss_cnt,
    output logic [15:0]                   timeout_cnt
);
    localparam int TAG_BITS  = EVENT_TAG_BITS;
    localparam int DATA_BITS = TAG_BITS + SIZE_BITS;
    localparam int DEPTH     = 2 ** ADDR_BITS;

    fetch_state_e           state_r, state_s;
    logic [TAG_BITS-1:0]    req_tag_r, last_tag_r;
    logic                   any_stored_r, served_r, rd_valid_r;
    logic [DEPTH-1:0]       entry_valid_r;
    logic [15:0]            wait_cnt_r;
    logic [15:0]            store_cnt_r, fetch_cnt_r, miss_cnt_r, timeout_cnt_r;
    logic                   tag_valid_r, fetch_hit_r, fetch_timeout_r;
    logic [SIZE_BITS-1:0]   fetch_size_r;

    logic [DATA_BITS-1:0]   rd_data_s;
    logic [ADDR_BITS-1:0]   store_idx_s, req_idx_s;
    logic                   store_match_s, rd_match_s;
    logic                   accept_s, resp_s, resp_hit_s, resp_timeout_s, miss_s, wait_clr_s;
    logic [SIZE_BITS-1:0]   resp_size_s;

    assign store_idx_s   = bus.store_tag[ADDR_BITS-1:0];
    assign req_idx_s     = req_tag_r[ADDR_BITS-1:0];
    assign store_match_s = bus.store_we && (bus.store_tag == req_tag_r);
    assign rd_match_s    = rd_valid_r && (rd_data_s[DATA_BITS-1:SIZE_BITS] == req_tag_r);

    ew_size_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_ram (
        .clk   (dreqclk),
        .rst   (reset_dreqclk),
        .we    (bus.store_we),
        .waddr (store_idx_s),
        .wdata ({bus.store_tag, bus.store_size}),
        .raddr (req_idx_s),
        .rdata (rd_data_s)
    );

    // Next-state and response decode; a same-cycle matching store beats the RAM copy
    always_comb begin
        state_s        = state_r;
        accept_s       = 1'b0;
        resp_s         = 1'b0;
        resp_hit_s     = 1'b0;
        resp_timeout_s = 1'b0;
        resp_size_s    = '0;
        miss_s         = 1'b0;
        wait_clr_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.tag_fetch && !served_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_READ;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_CMP;
            end
            ST_CMP: begin
                if (store_match_s) begin
                    resp_s      = 1'b1;
                    resp_hit_s  = 1'b1;
                    resp_size_s = bus.store_size;
                    state_s     = ST_IDLE;
                end else if (rd_match_s) begin
                    resp_s      = 1'b1;
                    resp_hit_s  = 1'b1;
                    resp_size_s = rd_data_s[SIZE_BITS-1:0];
                    state_s     = ST_IDLE;
                end else if (!any_stored_r || (req_tag_r > last_tag_r)) begin
                    wait_clr_s  = 1'b1;
                    state_s     = ST_WAIT;
                end else begin
                    resp_s      = 1'b1;
                    miss_s      = 1'b1;
                    state_s     = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (store_match_s) begin
                    resp_s      = 1'b1;
                    resp_hit_s  = 1'b1;
                    resp_size_s = bus.store_size;
                    state_s     = ST_IDLE;
                end else if (wait_cnt_r == (WAIT_CYCLES - 16'd1)) begin
                    resp_s         = 1'b1;
                    resp_timeout_s = 1'b1;
                    state_s        = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Fetch sequencing: state, latched request, once-per-level guard and wait timer
    always_ff @(posedge dreqclk) begin
        if (reset_dreqclk) begin
            state_r    <= ST_IDLE;
            req_tag_r  <= '0;
            served_r   <= 1'b0;
            wait_cnt_r <= 16'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                req_tag_r <= bus.evt_tag_fetch;
            end
            if (!bus.tag_fetch) begin
                served_r <= 1'b0;
            end else if (resp_s) begin
                served_r <= 1'b1;
            end
            if (wait_clr_s) begin
                wait_cnt_r <= 16'd0;
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 16'd1;
            end
        end
    end

    // Store bookkeeping; valid bits live here so reset forgets every record
    always_ff @(posedge dreqclk) begin
        if (reset_dreqclk) begin
            entry_valid_r <= '0;
            last_tag_r    <= '0;
            any_stored_r  <= 1'b0;
            rd_valid_r    <= 1'b0;
        end else begin
            if (bus.store_we) begin
                entry_valid_r[store_idx_s] <= 1'b1;
                last_tag_r                 <= bus.store_tag;
                any_stored_r               <= 1'b1;
            end
            rd_valid_r <= entry_valid_r[req_idx_s] || (bus.store_we && (store_idx_s == req_idx_s));
        end
    end

    // Response registers and saturating diagnostics
    always_ff @(posedge dreqclk) begin
        if (reset_dreqclk) begin
            tag_valid_r     <= 1'b0;
            fetch_size_r    <= '0;
            fetch_hit_r     <= 1'b0;
            fetch_timeout_r <= 1'b0;
            store_cnt_r     <= 16'd0;
            fetch_cnt_r     <= 16'd0;
            miss_cnt_r      <= 16'd0;
            timeout_cnt_r   <= 16'd0;
        end else begin
            tag_valid_r <= resp_s;
            if (resp_s || accept_s) begin
                fetch_size_r    <= resp_size_s;
                fetch_hit_r     <= resp_hit_s;
                fetch_timeout_r <= resp_timeout_s;
            end
            if (bus.store_we)   store_cnt_r   <= sat_inc(store_cnt_r);
            if (accept_s)       fetch_cnt_r   <= sat_inc(fetch_cnt_r);
            if (miss_s)         miss_cnt_r    <= sat_inc(miss_cnt_r);
            if (resp_timeout_s) timeout_cnt_r <= sat_inc(timeout_cnt_r);
        end
    end

    assign bus.tag_valid     = tag_valid_r;
    assign bus.fetch_size    = fetch_size_r;
    assign bus.fetch_hit     = fetch_hit_r;
    assign bus.fetch_timeout = fetch_timeout_r;
    assign store_cnt         = store_cnt_r;
    assign fetch_cnt         = fetch_cnt_r;
    assign miss_cnt          = miss_cnt_r;
    assign timeout_cnt       = timeout_cnt_r;
endmodule

// File: tb/tb_ew_size_store_and_fetch.sv
// Directed bench for ew_size_store_and_fetch: hit, miss, wait/bypass, timeout,
// write-first collision, reset while waiting and held-level single service.
module tb_ew_size_store_and_fetch;
    import ew_size_store_and_fetch_pkg::*;

    logic        dreqclk = 1'b0;
    logic        reset_dreqclk = 1'b1;
    logic [15:0] store_cnt, fetch_cnt, miss_cnt, timeout_cnt;
    int          checks = 0;
    int          errors = 0;
    int          n;
    int          pulses;

    ew_size_store_and_fetch_if #(.SIZE_BITS(10)) bus ();

    ew_size_store_and_fetch #(
        .ADDR_BITS   (8),
        .SIZE_BITS   (10),
        .WAIT_CYCLES (16'd4000)
    ) dut (
        .dreqclk       (dreqclk),
        .reset_dreqclk (reset_dreqclk),
        .bus           (bus),
        .store_cnt     (store_cnt),
        .fetch_cnt     (fetch_cnt),
        .miss_cnt      (miss_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 dreqclk = ~dreqclk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge dreqclk);
        #1;
    endtask

    task automatic do_reset();
        reset_dreqclk = 1'b1;
        tick();
        tick();
        reset_dreqclk = 1'b0;
    endtask

    task automatic do_store(input logic [47:0] tag, input logic [9:0] size);
        bus.store_we   = 1'b1;
        bus.store_tag  = tag;
        bus.store_size = size;
        tick();
        bus.store_we   = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!bus.tag_valid && cycles < max_cycles);
    endtask

    initial begin
        bus.store_we      = 1'b0;
        bus.store_tag     = 48'h0;
        bus.store_size    = 10'd0;
        bus.tag_fetch     = 1'b0;
        bus.evt_tag_fetch = 48'h0;
        do_reset();

        check("rst_tag_valid", bus.tag_valid, 1'b0);
        check("rst_size", bus.fetch_size, 10'd0);
        check("rst_hit", bus.fetch_hit, 1'b0);
        check("rst_counters", {store_cnt, fetch_cnt, miss_cnt, timeout_cnt}, 64'h0);

        // Straight hit
        do_store(48'h10, 10'd37);
        bus.tag_fetch = 1'b1; bus.evt_tag_fetch = 48'h10;
        wait_valid(20, n);
        check("hit_latency", n, 3);
        check("hit_size", bus.fetch_size, 10'd37);
        check("hit_flag", bus.fetch_hit, 1'b1);
        check("hit_timeout", bus.fetch_timeout, 1'b0);
        check("hit_fetch_cnt", fetch_cnt, 16'd1);
        check("hit_store_cnt", store_cnt, 16'd1);
        bus.tag_fetch = 1'b0;
        tick();
        check("pulse_width", bus.tag_valid, 1'b0);

        // Overwritten index, older tag -> immediate miss
        do_store(48'h05, 10'd7);
        do_store(48'h105, 10'd8);
        bus.tag_fetch = 1'b1; bus.evt_tag_fetch = 48'h05;
        wait_valid(20, n);
        check("miss_latency", n, 3);
        check("miss_size", bus.fetch_size, 10'd0);
        check("miss_hit", bus.fetch_hit, 1'b0);
        check("miss_cnt", miss_cnt, 16'd1);
        bus.tag_fetch = 1'b0;
        tick();

        // Newer tag waits, then is served by the store bypass
        do_store(48'h20, 10'd3);
        bus.tag_fetch = 1'b1; bus.evt_tag_fetch = 48'h22;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.tag_valid) pulses++;
        end
        do_store(48'h21, 10'd4);
        if (bus.tag_valid) pulses++;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.tag_valid) pulses++;
        end
        check("wait_no_early_pulse", pulses, 0);
        do_store(48'h22, 10'd9);
        check("bypass_valid", bus.tag_valid, 1'b1);
        check("bypass_size", bus.fetch_size, 10'd9);
        check("bypass_hit", bus.fetch_hit, 1'b1);
        bus.tag_fetch = 1'b0;
        tick();

        // Nothing stored -> timeout
        do_reset();
        bus.tag_fetch = 1'b1; bus.evt_tag_fetch = 48'h30;
        wait_valid(5000, n);
        check("timeout_latency", n, 4003);
        check("timeout_flag", bus.fetch_timeout, 1'b1);
        check("timeout_size", bus.fetch_size, 10'd0);
        check("timeout_hit", bus.fetch_hit, 1'b0);
        check("timeout_cnt", timeout_cnt, 16'd1);
        check("timeout_miss_cnt", miss_cnt, 16'd0);
        bus.tag_fetch = 1'b0;
        tick();

        // Store colliding with the RAM read of the same tag
        bus.tag_fetch = 1'b1; bus.evt_tag_fetch = 48'h40;
        tick();
        do_store(48'h40, 10'd12);
        wait_valid(20, n);
        check("wf_latency", n, 1);
        check("wf_size", bus.fetch_size, 10'd12);
        check("wf_hit", bus.fetch_hit, 1'b1);
        bus.tag_fetch = 1'b0;
        tick();

        // Reset while waiting, then a pre-reset tag must wait again
        do_store(48'h50, 10'd5);
        bus.tag_fetch = 1'b1; bus.evt_tag_fetch = 48'h60;
        for (int i = 0; i < 5; i++) tick();
        pulses = 0;
        bus.tag_fetch = 1'b0;
        reset_dreqclk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.tag_valid) pulses++;
        end
        reset_dreqclk = 1'b0;
        tick();
        if (bus.tag_valid) pulses++;
        check("rstwait_no_pulse", pulses, 0);
        check("rstwait_counters", {store_cnt, fetch_cnt, miss_cnt, timeout_cnt}, 64'h0);
        bus.tag_fetch = 1'b1; bus.evt_tag_fetch = 48'h50;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.tag_valid) pulses++;
        end
        check("rstwait_refetch_waits", pulses, 0);
        do_store(48'h50, 10'd6);
        check("rstwait_bypass_valid", bus.tag_valid, 1'b1);
        check("rstwait_bypass_size", bus.fetch_size, 10'd6);
        bus.tag_fetch = 1'b0;
        tick();

        // Held fetch level is serviced exactly once
        do_reset();
        do_store(48'h70, 10'd1);
        bus.tag_fetch = 1'b1; bus.evt_tag_fetch = 48'h70;
        wait_valid(20, n);
        check("hold_latency", n, 3);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.tag_valid) pulses++;
        end
        check("hold_single_pulse", pulses, 0);
        check("hold_fetch_cnt", fetch_cnt, 16'd1);
        bus.tag_fetch = 1'b0;
        tick();
        bus.tag_fetch = 1'b1;
        wait_valid(20, n);
        check("refetch_latency", n, 3);
        check("refetch_fetch_cnt", fetch_cnt, 16'd2);
        bus.tag_fetch = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
